// File: rtl/serial_tx.sv
// serial_tx: parallel-in, serial-out frame transmitter.
// Sends start bit, NUM_BITS data bits, an optional parity bit and a stop bit.
// Every bit is held for BIT_CYCLES clocks. tx comes straight from a flop.
module serial_tx #(
  parameter int NUM_BITS   = 8,
  parameter int BIT_CYCLES = 4,
  parameter int LSB_FIRST  = 1,
  parameter int PARITY     = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [NUM_BITS-1:0] dat_in,
  output logic                ready,
  output logic                tx,
  output logic                busy,
  output logic                done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  // One spare bit keeps BW at 1 or more when BIT_CYCLES is 1.
  localparam int BW = $clog2(BIT_CYCLES + 1);
  localparam int DW = $clog2(NUM_BITS);
  localparam logic [BW-1:0] BCNT_LAST = BW'(BIT_CYCLES - 1);
  localparam logic [DW-1:0] DCNT_LAST = DW'(NUM_BITS - 1);

  state_t              state_q, state_d;
  logic [BW-1:0]       bcnt_q, bcnt_d;
  logic [DW-1:0]       dcnt_q, dcnt_d;
  logic [NUM_BITS-1:0] sreg_q, sreg_d;
  logic                par_q, par_d;
  logic                tx_q, tx_d;
  logic                done_q, done_d;
  logic                bit_end;

  assign bit_end = (bcnt_q == BCNT_LAST);

  // Next state, bit timing, shifting, and the value tx takes next cycle.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (which would infer a latch).
    state_d = state_q;
    bcnt_d  = bcnt_q;
    dcnt_d  = dcnt_q;
    sreg_d  = sreg_q;
    par_d   = par_q;
    done_d  = 1'b0;
    tx_d    = 1'b1;

    if (state_q != S_IDLE) begin
      bcnt_d = bit_end ? '0 : bcnt_q + BW'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (load) begin
          sreg_d  = dat_in;
          par_d   = (PARITY == 2) ? ~^dat_in : ^dat_in;
          bcnt_d  = '0;
          dcnt_d  = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        if (bit_end) begin
          if (dcnt_q == DCNT_LAST) begin
            dcnt_d  = '0;
            state_d = (PARITY != 0) ? S_PAR : S_STOP;
          end else begin
            dcnt_d = dcnt_q + DW'(1);
            sreg_d = (LSB_FIRST != 0) ? (sreg_q >> 1) : (sreg_q << 1);
          end
        end
      end
      S_PAR: begin
        if (bit_end) state_d = S_STOP;
      end
      S_STOP: begin
        if (bit_end) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // tx is registered, so it is derived from the state being entered.
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = (LSB_FIRST != 0) ? sreg_d[0] : sreg_d[NUM_BITS-1];
      S_PAR:   tx_d = par_d;
      default: tx_d = 1'b1;
    endcase
  end

  // State register; reset abandons any frame in flight and parks the line high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state_q <= S_IDLE;
      bcnt_q  <= '0;
      dcnt_q  <= '0;
      sreg_q  <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      dcnt_q  <= dcnt_d;
      sreg_q  <= sreg_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  assign ready = (state_q == S_IDLE);
  assign busy  = (state_q != S_IDLE);
  assign tx    = tx_q;
  assign done  = done_q;

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx: four parameterisations share clk and reset.
// u0: defaults, u1: even parity, u2: odd parity, u3: MSB first with BIT_CYCLES=1.
module tb_serial_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] load_v;
  logic [7:0] dat_v [4];
  logic [3:0] tx_v, busy_v, ready_v, done_v;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  serial_tx #(.NUM_BITS(8), .BIT_CYCLES(4), .LSB_FIRST(1), .PARITY(0)) u0 (
    .clk(clk), .reset(reset), .load(load_v[0]), .dat_in(dat_v[0]),
    .ready(ready_v[0]), .tx(tx_v[0]), .busy(busy_v[0]), .done(done_v[0]));
  serial_tx #(.NUM_BITS(8), .BIT_CYCLES(4), .LSB_FIRST(1), .PARITY(1)) u1 (
    .clk(clk), .reset(reset), .load(load_v[1]), .dat_in(dat_v[1]),
    .ready(ready_v[1]), .tx(tx_v[1]), .busy(busy_v[1]), .done(done_v[1]));
  serial_tx #(.NUM_BITS(8), .BIT_CYCLES(4), .LSB_FIRST(1), .PARITY(2)) u2 (
    .clk(clk), .reset(reset), .load(load_v[2]), .dat_in(dat_v[2]),
    .ready(ready_v[2]), .tx(tx_v[2]), .busy(busy_v[2]), .done(done_v[2]));
  serial_tx #(.NUM_BITS(8), .BIT_CYCLES(1), .LSB_FIRST(0), .PARITY(0)) u3 (
    .clk(clk), .reset(reset), .load(load_v[3]), .dat_in(dat_v[3]),
    .ready(ready_v[3]), .tx(tx_v[3]), .busy(busy_v[3]), .done(done_v[3]));

  // mode 0: plain, 1: scramble dat_in after accept, 2: stray load of 0x3C mid-frame
  typedef struct {
    int         sel;
    logic [7:0] data;
    int         mode;
    logic [0:11] bits;   // expected line bits in transmit order, index 0 first
    int         nbits;
    string      name;
  } vec_t;

  vec_t vecs [8];

  function automatic int bc_of(input int sel);
    return (sel == 3) ? 1 : 4;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Follows one frame from the first START cycle through the done cycle.
  task automatic capture(input int sel, input logic [0:11] bits, input int nbits,
                         input int mode, input string name);
    int   bc;
    int   cyc;
    logic got;
    logic rdy_bad, done_bad;
    bc       = bc_of(sel);
    cyc      = 0;
    rdy_bad  = 1'b0;
    done_bad = 1'b0;
    for (int b = 0; b < nbits; b++) begin
      got = bits[b];
      for (int c = 0; c < bc; c++) begin
        @(negedge clk);
        if (tx_v[sel] !== bits[b]) got = tx_v[sel];
        if (ready_v[sel] !== 1'b0 || busy_v[sel] !== 1'b1) rdy_bad = 1'b1;
        if (done_v[sel] !== 1'b0) done_bad = 1'b1;
        if (mode == 1) dat_v[sel] = 8'($urandom);
        if (mode == 2) begin
          load_v[sel] = (cyc == 10);
          if (cyc == 10) dat_v[sel] = 8'h3C;
        end
        cyc++;
      end
      check($sformatf("%s bit%0d", name, b), {31'd0, got}, {31'd0, bits[b]});
    end
    load_v[sel] = (mode == 3);
    check({name, " ready_low"}, {31'd0, rdy_bad}, 32'd0);
    check({name, " done_quiet"}, {31'd0, done_bad}, 32'd0);
    @(negedge clk);
    check({name, " done_pulse"}, {28'd0, done_v[sel], ready_v[sel], busy_v[sel], tx_v[sel]},
          {28'd0, 4'b1101});
  endtask

  task automatic run_frame(input vec_t v);
    @(negedge clk);
    check({v.name, " ready_pre"}, {31'd0, ready_v[v.sel]}, 32'd1);
    load_v[v.sel] = 1'b1;
    dat_v[v.sel]  = v.data;
    @(posedge clk);
    #1;
    load_v[v.sel] = 1'b0;
    capture(v.sel, v.bits, v.nbits, v.mode, v.name);
    @(negedge clk);
    check({v.name, " idle_after"}, {30'd0, busy_v[v.sel], tx_v[v.sel]}, 32'd1);
  endtask

  initial begin
    logic bad;
    vecs[0] = '{0, 8'hA5, 0, 12'b0101_0010_1100, 10, "basic_a5"};
    vecs[1] = '{1, 8'hA5, 0, 12'b0101_0010_1010, 11, "even_a5"};
    vecs[2] = '{2, 8'h07, 0, 12'b0111_0000_0010, 11, "odd_07"};
    vecs[3] = '{1, 8'h07, 0, 12'b0111_0000_0110, 11, "even_07"};
    vecs[4] = '{3, 8'h81, 0, 12'b0100_0000_1100, 10, "msb_81"};
    vecs[5] = '{0, 8'hF0, 1, 12'b0000_0111_1100, 10, "stable_f0"};
    vecs[6] = '{0, 8'h5A, 2, 12'b0010_1101_0100, 10, "ignore_load"};
    vecs[7] = '{3, 8'h3C, 0, 12'b0001_1110_0100, 10, "msb_3c"};

    reset  = 1'b1;
    load_v = '0;
    for (int i = 0; i < 4; i++) dat_v[i] = '0;
    repeat (3) @(negedge clk);
    check("reset_tx",    {28'd0, tx_v},    32'hF);
    check("reset_ready", {28'd0, ready_v}, 32'hF);
    check("reset_busy",  {28'd0, busy_v},  32'h0);
    check("reset_done",  {28'd0, done_v},  32'h0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 8; i++) run_frame(vecs[i]);

    // Back-to-back: load held high across the done cycle of the first frame.
    @(negedge clk);
    load_v[0] = 1'b1;
    dat_v[0]  = 8'h55;
    @(posedge clk);
    #1;
    dat_v[0] = 8'hAA;
    capture(0, 12'b0101_0101_0100, 10, 3, "b2b_55");
    @(posedge clk);
    #1;
    load_v[0] = 1'b0;
    capture(0, 12'b0010_1010_1100, 10, 0, "b2b_aa");
    @(negedge clk);
    check("b2b idle_after", {30'd0, busy_v[0], tx_v[0]}, 32'd1);

    // Reset mid-DATA abandons the frame at once, with no done afterwards.
    @(negedge clk);
    load_v[0] = 1'b1;
    dat_v[0]  = 8'hA5;
    @(posedge clk);
    #1;
    load_v[0] = 1'b0;
    repeat (12) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midreset_now", {29'd0, tx_v[0], busy_v[0], ready_v[0]}, 32'b101);
    @(negedge clk);
    reset = 1'b0;
    bad = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (tx_v[0] !== 1'b1 || done_v[0] !== 1'b0 || busy_v[0] !== 1'b0) bad = 1'b1;
    end
    check("midreset_after", {31'd0, bad}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
